// File: rtl/vec_load_collector.sv
// Vector load collector: gathers NUM_WORDS memory words into one packed vector,
// filled in ascending or descending index order, tagged with a destination register.
module vec_load_collector #(
    parameter int DATA_W    = 16,
    parameter int NUM_WORDS = 16,
    parameter int RD_W      = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        desc_mode,
    input  logic [RD_W-1:0]             rd_in,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        out_valid,
    output logic [RD_W-1:0]             rd_out,
    output logic [NUM_WORDS*DATA_W-1:0] out_data
);

    localparam int IDX_W = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cnt;
    logic             desc;
    logic             last_word;

    // Completion is decided by the accepted-word count, so idx never steps past the end.
    assign last_word = (state == COLLECT) && in_valid && (cnt == IDX_W'(NUM_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? COLLECT : IDLE;
            COLLECT:    if (last_word) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            rd_out    <= '0;
            out_valid <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            desc      <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
        end else if (state != COLLECT) begin
            if (start) begin
                rd_out    <= rd_in;
                desc      <= desc_mode;
                idx       <= desc_mode ? IDX_W'(NUM_WORDS - 1) : '0;
                cnt       <= '0;
                out_valid <= 1'b0;
            end
        end else if (in_valid) begin
            out_data[int'(idx)*DATA_W +: DATA_W] <= in_data;
            if (last_word) begin
                out_valid <= 1'b1;
            end else begin
                idx <= desc ? idx - IDX_W'(1) : idx + IDX_W'(1);
                cnt <= cnt + IDX_W'(1);
            end
        end
    end

    assign busy = (state == COLLECT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_vec_load_collector.sv
// Directed self-checking bench for vec_load_collector at default parameters.
module tb_vec_load_collector;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         desc_mode = 1'b0;
    logic [4:0]   rd_in = '0;
    logic         in_valid = 1'b0;
    logic [15:0]  in_data = '0;
    logic         abort = 1'b0;
    logic         busy;
    logic         done;
    logic         out_valid;
    logic [4:0]   rd_out;
    logic [255:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [255:0] expv;

    vec_load_collector #(.DATA_W(16), .NUM_WORDS(16), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .desc_mode(desc_mode), .rd_in(rd_in),
        .in_valid(in_valid), .in_data(in_data), .abort(abort), .busy(busy),
        .done(done), .out_valid(out_valid), .rd_out(rd_out), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected vector for a full fill of words base, base+1, ... in the given order.
    function automatic logic [255:0] fill_vec(input logic [15:0] base, input logic dsc);
        logic [255:0] v = '0;
        for (int i = 0; i < 16; i++) begin
            if (dsc) v[(15-i)*16 +: 16] = base + 16'(i);
            else     v[i*16 +: 16]      = base + 16'(i);
        end
        return v;
    endfunction

    task automatic do_start(input logic [4:0] rd, input logic dsc);
        start = 1'b1; rd_in = rd; desc_mode = dsc;
        tick();
        start = 1'b0;
    endtask

    // Feeds 16 consecutive words; done must appear exactly after the 16th.
    task automatic fill16(input string tag, input logic [15:0] base);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = base + 16'(i);
            tick();
            if (i == 14) chk({tag, "_done_early"}, 256'(done), 256'(0));
        end
        in_valid = 1'b0;
        chk({tag, "_done"}, 256'(done), 256'(1));
        chk({tag, "_out_valid"}, 256'(out_valid), 256'(1));
        chk({tag, "_busy_end"}, 256'(busy), 256'(0));
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_rd_out", 256'(rd_out), 256'(0));
        chk("rst_out_data", out_data, 256'(0));
        tick();
        rst = 1'b0;
        tick();

        // Ascending fill
        do_start(5'd7, 1'b0);
        chk("asc_busy", 256'(busy), 256'(1));
        chk("asc_ov_low", 256'(out_valid), 256'(0));
        fill16("asc", 16'h1000);
        chk("asc_data", out_data, fill_vec(16'h1000, 1'b0));
        chk("asc_rd", 256'(rd_out), 256'(7));
        tick();
        chk("asc_done_pulse", 256'(done), 256'(0));
        chk("asc_idle_ov", 256'(out_valid), 256'(1));
        chk("asc_idle_busy", 256'(busy), 256'(0));
        chk("asc_done_count", 256'(done_cnt), 256'(1));

        // Descending fill
        do_start(5'd9, 1'b1);
        fill16("desc", 16'hA000);
        chk("desc_data", out_data, fill_vec(16'hA000, 1'b1));
        chk("desc_w15", 256'(out_data[255:240]), 256'(16'hA000));
        chk("desc_w0", 256'(out_data[15:0]), 256'(16'hA00F));
        chk("desc_rd", 256'(rd_out), 256'(9));
        tick();

        // Stalled fill: in_valid 0,1,0,1,... so done lands 33 cycles after start
        do_start(5'd7, 1'b0);
        chk("stall_ov_low", 256'(out_valid), 256'(0));
        for (int k = 0; k < 32; k++) begin
            in_valid = k[0];
            in_data  = k[0] ? 16'h1000 + 16'(k / 2) : 16'hDEAD;
            tick();
            if (k < 31) begin
                chk($sformatf("stall_busy_%0d", k), 256'(busy), 256'(1));
                chk($sformatf("stall_done_%0d", k), 256'(done), 256'(0));
            end
        end
        in_valid = 1'b0;
        chk("stall_done", 256'(done), 256'(1));
        chk("stall_data", out_data, fill_vec(16'h1000, 1'b0));
        tick();

        // Abort after 5 words; abort beats start and in_valid in the same cycle
        do_start(5'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'h5550 + 16'(i);
            tick();
        end
        abort = 1'b1; start = 1'b1; rd_in = 5'd2; in_valid = 1'b1; in_data = 16'h9999;
        tick();
        abort = 1'b0; start = 1'b0;
        expv = fill_vec(16'h1000, 1'b0);
        for (int i = 0; i < 5; i++) expv[i*16 +: 16] = 16'h5550 + 16'(i);
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_done", 256'(done), 256'(0));
        chk("abort_ov", 256'(out_valid), 256'(0));
        chk("abort_rd", 256'(rd_out), 256'(1));
        chk("abort_data", out_data, expv);
        tick();
        in_valid = 1'b0;
        chk("idle_ignore_data", out_data, expv);
        chk("idle_ignore_busy", 256'(busy), 256'(0));
        do_start(5'd3, 1'b0);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 16'hBEEF;
            tick();
        end
        in_valid = 1'b0;
        chk("beef_done", 256'(done), 256'(1));
        chk("beef_data", out_data, {16{16'hBEEF}});
        chk("beef_rd", 256'(rd_out), 256'(3));
        tick();

        // Reset mid-collection, start held through reset
        do_start(5'd4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 16'h2220 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_data", out_data, 256'(0));
        chk("mrst_ov", 256'(out_valid), 256'(0));
        chk("mrst_busy", 256'(busy), 256'(0));
        chk("mrst_rd", 256'(rd_out), 256'(0));
        start = 1'b1; rd_in = 5'd6; desc_mode = 1'b0;
        tick();
        chk("mrst_start_ignored", 256'(busy), 256'(0));
        rst = 1'b0;
        tick();
        start = 1'b0;
        chk("post_rst_busy", 256'(busy), 256'(1));
        chk("post_rst_rd", 256'(rd_out), 256'(6));
        fill16("post_rst", 16'h3000);
        chk("post_rst_data", out_data, fill_vec(16'h3000, 1'b0));

        // Start from DONE with same-cycle in_valid, then a start mid-collection
        start = 1'b1; rd_in = 5'd12; desc_mode = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF;
        tick();
        start = 1'b0;
        chk("sc_busy", 256'(busy), 256'(1));
        chk("sc_ov_low", 256'(out_valid), 256'(0));
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 16'h4000 + 16'(i);
            start = (i == 3); rd_in = 5'd20; desc_mode = 1'b1;
            tick();
        end
        start = 1'b0; in_valid = 1'b0;
        chk("sc_done", 256'(done), 256'(1));
        chk("sc_data", out_data, fill_vec(16'h4000, 1'b0));
        chk("sc_rd", 256'(rd_out), 256'(12));
        tick();
        chk("total_done_count", 256'(done_cnt), 256'(6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
